// File: rtl/aes_ctr_block_sequencer_if.sv
// Counter-block stream between the CTR sequencer and the AES-128 core.
// Valid/ready handshake; the sequencer is the master.
interface aes_ctr_block_sequencer_if;
   localparam int unsigned BLK_W = 128;

   logic [BLK_W-1:0] ctr_block;
   logic             ctr_valid;
   logic             ctr_ready;
   logic             ctr_last;

   modport master (output ctr_block, output ctr_valid, output ctr_last, input  ctr_ready);
   modport slave  (input  ctr_block, input  ctr_valid, input  ctr_last, output ctr_ready);
endinterface

// File: rtl/aes_ctr_block_sequencer.sv
// Captures one LFSR IV per message, pulses the LFSR enable once, and streams
// CTR-mode counter blocks {nonce, counter} to the AES-128 core.
module aes_ctr_block_sequencer #(
   parameter int unsigned CTR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      msg_start,
   input  logic [CNT_WIDTH-1:0]      msg_blocks,
   input  logic [127:0]              lfsr_iv,
   output logic                      lfsr_enable,
   output logic [127:0]              iv_used,
   aes_ctr_block_sequencer_if.master ctr,
   output logic                      busy,
   output logic                      done
);
   localparam int unsigned BLK_W = 128;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_EMIT    = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [BLK_W-1:0]     r_iv_used;
   logic [BLK_W-1:0]     w_iv_used_nxt;
   logic [CTR_WIDTH-1:0] r_counter;
   logic [CTR_WIDTH-1:0] w_counter_nxt;
   logic [CNT_WIDTH-1:0] r_remaining;
   logic [CNT_WIDTH-1:0] w_remaining_nxt;
   logic                 w_last;

   // State and datapath registers; reset aborts any message in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_iv_used   <= '0;
         r_counter   <= '0;
         r_remaining <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_iv_used   <= w_iv_used_nxt;
         r_counter   <= w_counter_nxt;
         r_remaining <= w_remaining_nxt;
      end
   end

   assign w_last = (r_remaining == CNT_WIDTH'(1));

   // Next-state and datapath update; outputs decode registered state only.
   always_comb begin
      w_state_nxt     = r_state;
      w_iv_used_nxt   = r_iv_used;
      w_counter_nxt   = r_counter;
      w_remaining_nxt = r_remaining;
      lfsr_enable     = 1'b0;
      busy            = 1'b1;
      done            = 1'b0;
      ctr.ctr_valid   = 1'b0;
      ctr.ctr_last    = 1'b0;

      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (msg_start && (msg_blocks != '0)) begin
               w_iv_used_nxt   = lfsr_iv;
               w_counter_nxt   = lfsr_iv[CTR_WIDTH-1:0];
               w_remaining_nxt = msg_blocks;
               w_state_nxt     = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            lfsr_enable = 1'b1;
            w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            ctr.ctr_valid = 1'b1;
            ctr.ctr_last  = w_last;
            // Counter wraps inside its field; the nonce bits never see a carry.
            if (ctr.ctr_ready) begin
               w_counter_nxt   = r_counter + CTR_WIDTH'(1);
               w_remaining_nxt = r_remaining - CNT_WIDTH'(1);
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign iv_used       = r_iv_used;
   assign ctr.ctr_block = {r_iv_used[BLK_W-1:CTR_WIDTH], r_counter};

endmodule

// File: tb/tb_aes_ctr_block_sequencer.sv
// Self-checking bench: randomized messages checked against a list-based
// reference of expected counter blocks, with a behavioural 128-bit LFSR.
module tb_aes_ctr_block_sequencer;
   localparam int unsigned CTR_W = 32;
   localparam int unsigned CNT_W = 16;
   localparam logic [127:0] TAPS = {8'hE1, 120'h0};

   logic              clk;
   logic              rst;
   logic              msg_start;
   logic [CNT_W-1:0]  msg_blocks;
   logic [127:0]      lfsr_iv;
   logic              lfsr_enable;
   logic [127:0]      iv_used;
   logic              busy;
   logic              done;

   logic [127:0]      lfsr;
   logic              load_en;
   logic [127:0]      load_val;

   int n_checks;
   int n_errors;

   aes_ctr_block_sequencer_if u_if();

   aes_ctr_block_sequencer #(.CTR_WIDTH(CTR_W), .CNT_WIDTH(CNT_W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .msg_start   (msg_start),
      .msg_blocks  (msg_blocks),
      .lfsr_iv     (lfsr_iv),
      .lfsr_enable (lfsr_enable),
      .iv_used     (iv_used),
      .ctr         (u_if.master),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] lfsr_next(input logic [127:0] s);
      logic [127:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ TAPS;
      return n;
   endfunction

   // Behavioural IV generator: advances once per enable, loadable by the bench.
   always @(posedge clk) begin
      if (load_en)          lfsr <= load_val;
      else if (lfsr_enable) lfsr <= lfsr_next(lfsr);
   end
   assign lfsr_iv = lfsr;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_en"},    128'(lfsr_enable),     128'd0);
      check({tag, "_iv"},    iv_used,               128'd0);
      check({tag, "_blk"},   u_if.ctr_block,        128'd0);
      check({tag, "_valid"}, 128'(u_if.ctr_valid),  128'd0);
      check({tag, "_last"},  128'(u_if.ctr_last),   128'd0);
      check({tag, "_busy"},  128'(busy),            128'd0);
      check({tag, "_done"},  128'(done),            128'd0);
   endtask

   task automatic load_lfsr(input logic [127:0] v);
      load_en  = 1'b1;
      load_val = v;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   // Runs one message starting at the current negedge. stall_pct<0 selects a
   // fixed 5-cycle stall on the first block.
   task automatic run_msg(input int n, input int stall_pct, input int restart_at,
                          input int rst_at, output logic [127:0] iv_out);
      logic [127:0] exp_iv, exp_blk, held;
      logic [127:0] got_q[$];
      logic         got_last_q[$];
      int           en_cnt, done_cyc;
      bit           stalled_prev, all_ready, aborted;
      exp_iv = lfsr;
      iv_out = exp_iv;
      en_cnt = 0; done_cyc = -1;
      stalled_prev = 1'b0; all_ready = 1'b1; aborted = 1'b0; held = '0;
      msg_start = 1'b1;
      msg_blocks = CNT_W'(n);
      u_if.ctr_ready = 1'b0;
      for (int c = 1; c <= 4 * n + 40; c++) begin
         @(negedge clk);
         msg_start  = (c == restart_at);
         msg_blocks = (c == restart_at) ? CNT_W'(n + 3) : CNT_W'(n);
         if (lfsr_enable) en_cnt++;
         if (c == 1) begin
            check("cap_iv",   iv_used,            exp_iv);
            check("cap_busy", 128'(busy),         128'd1);
            check("cap_en",   128'(lfsr_enable),  128'd1);
         end
         if (stalled_prev) begin
            check("hold_blk",   u_if.ctr_block,       held);
            check("hold_valid", 128'(u_if.ctr_valid), 128'd1);
         end
         if (c == rst_at) begin
            rst = 1'b1; msg_start = 1'b0; u_if.ctr_ready = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_idle_zero("abort");
            check("abort_en_cnt", 128'(en_cnt), 128'd1);
            aborted = 1'b1;
            break;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
         if (stall_pct < 0) u_if.ctr_ready = !(c >= 2 && c <= 6);
         else               u_if.ctr_ready = ($urandom_range(0, 99) >= stall_pct);
         if (u_if.ctr_valid && !u_if.ctr_ready) all_ready = 1'b0;
         stalled_prev = u_if.ctr_valid && !u_if.ctr_ready;
         held = u_if.ctr_block;
         if (u_if.ctr_valid && u_if.ctr_ready) begin
            got_q.push_back(u_if.ctr_block);
            got_last_q.push_back(u_if.ctr_last);
         end
      end
      if (!aborted) begin
         check("done_seen", 128'(done_cyc >= 0), 128'd1);
         check("blk_count", 128'(got_q.size()), 128'(n));
         for (int i = 0; i < n && i < got_q.size(); i++) begin
            exp_blk = exp_iv;
            exp_blk[CTR_W-1:0] = exp_iv[CTR_W-1:0] + CTR_W'(i);
            check($sformatf("blk%0d", i),  got_q[i],            exp_blk);
            check($sformatf("last%0d", i), 128'(got_last_q[i]), 128'(i == n - 1));
         end
         check("en_cnt", 128'(en_cnt), 128'd1);
         if (all_ready) check("done_cycle", 128'(done_cyc), 128'(n + 2));
         check("lfsr_adv", lfsr, lfsr_next(exp_iv));
         @(negedge clk);
         msg_start = 1'b0;
         check("post_done",  128'(done),           128'd0);
         check("post_busy",  128'(busy),           128'd0);
         check("post_valid", 128'(u_if.ctr_valid), 128'd0);
         check("post_iv",    iv_used,              exp_iv);
      end
   endtask

   initial begin
      logic [127:0] iv_a, iv_b, l0, seed;
      n_checks = 0; n_errors = 0;
      rst = 1'b1; msg_start = 1'b0; msg_blocks = '0; u_if.ctr_ready = 1'b0;
      load_en = 1'b0; load_val = '0;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;

      load_lfsr(128'h1);
      run_msg(3, 0, -1, -1, iv_a);

      load_lfsr(128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_FFFF_FFFE);
      run_msg(4, 0, -1, -1, iv_a);

      run_msg(2, -1, -1, -1, iv_a);

      // Zero-length request is ignored entirely.
      l0 = lfsr;
      msg_start = 1'b1; msg_blocks = '0;
      @(negedge clk);
      msg_start = 1'b0;
      check("zero_busy", 128'(busy),        128'd0);
      check("zero_en",   128'(lfsr_enable), 128'd0);
      @(negedge clk);
      check("zero_busy2", 128'(busy), 128'd0);
      check("zero_done",  128'(done), 128'd0);
      check("zero_lfsr",  lfsr,       l0);

      run_msg(10, 0, 2, 3, iv_a);
      run_msg(2, 0, -1, -1, iv_a);

      // Back-to-back single-block messages take successive LFSR states.
      run_msg(1, 0, -1, -1, iv_a);
      for (int m = 0; m < 4; m++) begin
         run_msg(1, 0, -1, -1, iv_b);
         check("b2b_iv_diff", 128'(iv_b != iv_a), 128'd1);
         check("b2b_iv_next", iv_b, lfsr_next(iv_a));
         iv_a = iv_b;
      end

      for (int m = 0; m < 20; m++) begin
         if ($urandom_range(0, 3) == 0) begin
            seed = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) seed[CTR_W-1:0] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            load_lfsr(seed);
         end
         run_msg(int'($urandom_range(1, 8)), 30, -1, -1, iv_a);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/aes_ctr_block_sequencer.md
# aes_ctr_block_sequencer

Downstream consumer of the 128-bit Galois LFSR IV generator in the AES-128 datapath. For each message it captures one IV from the LFSR and pulses the LFSR's `enable` for exactly one cycle so the next message gets a fresh IV. It then streams CTR-mode counter blocks (nonce‖counter) to the AES-128 encryption core over a valid/ready handshake. It also exposes the IV used so the framing logic can transmit it with the ciphertext.

## Interface
- `CTR_WIDTH`, default 32: width of the incrementing counter field in the low bits of the block; legal range 8–64.
- `CNT_WIDTH`, default 16: width of the per-message block-count input.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `msg_start`  in  1  one-cycle request to begin a message; sampled only in IDLE.
- `msg_blocks`  in  CNT_WIDTH  number of 128-bit blocks in the message; sampled with `msg_start`.
- `lfsr_iv`  in  128  current LFSR output (`iv` of the generator).
- `lfsr_enable`  out  1  drives the LFSR `enable`; high for exactly one cycle per accepted message.
- `iv_used`  out  128  IV captured for the current/last message; held until the next capture.
- `ctr_block`  out  128  counter block to the AES core: {iv_used[127:CTR_WIDTH], counter}.
- `ctr_valid`  out  1  `ctr_block` is valid.
- `ctr_ready`  in  1  AES core accepts the block.
- `ctr_last`  out  1  high with `ctr_valid` on the final block of the message.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the final block handshake.

## Operation
- FSM states: IDLE, CAPTURE, EMIT, DONE. All outputs are registered or decoded from registered state.
- IDLE: if `msg_start`=1 and `msg_blocks`≠0, latch `lfsr_iv` into `iv_used` and the counter register, latch `msg_blocks` into `remaining`, then go to CAPTURE. If `msg_blocks`=0, the request is ignored: no state change, no `lfsr_enable`, no `done`.
- CAPTURE (1 cycle): `lfsr_enable`=1. The LFSR advances on the closing edge. Next state is EMIT.
- EMIT: `ctr_valid`=1; `ctr_last`=1 when `remaining`=1.
  - On `ctr_valid && ctr_ready`: counter ← counter+1 mod 2^CTR_WIDTH. The upper 128−CTR_WIDTH nonce bits never change, so wrap from all-ones to 0 does not carry into the nonce. `remaining` decrements.
  - If the accepted block was last, go to DONE.
  - While `ctr_ready`=0, `ctr_block`, `ctr_valid` and `ctr_last` hold stable.
- DONE (1 cycle): `done`=1, `ctr_valid`=0, then go to IDLE.
- `msg_start` outside IDLE is ignored and never queued.
- The first block equals the captured IV unchanged. The counter starts at `lfsr_iv[CTR_WIDTH-1:0]`.
- `rst` mid-message: abort immediately. Next cycle is IDLE with all outputs at reset values. `iv_used` is cleared. No `done` is issued.

## Timing
- Reset values: `lfsr_enable`=0, `iv_used`=0, `ctr_block`=0, `ctr_valid`=0, `ctr_last`=0, `busy`=0, `done`=0; state IDLE, `remaining`=0.
- Start accepted at edge E0 → cycle 1: CAPTURE, `busy`=1, `lfsr_enable`=1, `iv_used` valid → cycle 2: first `ctr_valid`.
- Throughput: 1 block/cycle with `ctr_ready` held high. For N blocks, the last handshake is in cycle N+1, `done` is in cycle N+2, and a new `msg_start` is accepted in cycle N+3.
- The IV-to-next-IV separation is guaranteed: exactly one `lfsr_enable` pulse per accepted message, never asserted in IDLE, EMIT or DONE.
- Latency from `ctr_ready` to the next block is zero bubbles: the counter updates on the handshake edge.

## Test plan
- Reset, then `msg_start`, `msg_blocks`=3, `lfsr_iv`=128'h1, ready high → blocks 128'h1, 128'h2, 128'h3; `ctr_last` only on the third; `done` in cycle 5; one `lfsr_enable` pulse in cycle 1.
- `lfsr_iv`=128'hAAAA…_FFFF_FFFE, CTR_WIDTH=32, 4 blocks → counter fields …FFFE, …FFFF, 0000_0000, 0000_0001; upper 96 bits constant.
- 2 blocks with `ctr_ready` low for 5 cycles on block 1 → `ctr_block`=IV held stable; no counter advance; no duplicate or skipped block.
- `msg_start` with `msg_blocks`=0 → `busy`, `lfsr_enable` and `done` stay 0; the LFSR IV is unchanged.
- `msg_start` pulsed during EMIT, and `rst` asserted in the 2nd EMIT cycle of a 10-block message → second start ignored; after reset all outputs are 0 and IDLE; the next message restarts cleanly with a single `lfsr_enable`.
- Back-to-back messages of 1 block each, driven by the real LFSR → `iv_used` differs between messages, matching successive LFSR states.
